// File: rtl/writeback_scoreboard.sv
// Writeback scoreboard: tracks pending register writes and registers the register-file write port.
// Latency: a writeback sampled at posedge N appears on we_RF/A3/WD3 after posedge N; stall_out is combinational.
// Backpressure: stall_out holds issue while a source or destination has a pending write; writeback is never held.
module writeback_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_data,
  input  logic [31:0] pc_plus4,
  input  logic        flush,
  output logic        stall_out,
  output logic        we_RF,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic [31:0] busy,
  output logic [31:0] retire_cnt
);

  logic [31:0] sel_data;
  logic        commit;
  logic        set_en;
  logic        clr_en;

  // Pick the writeback value; the illegal select yields zero so WD3 stays deterministic
  always_comb begin
    sel_data = 32'd0;
    case (wb_sel)
      2'b00:   sel_data = alu_result;
      2'b01:   sel_data = mem_data;
      2'b10:   sel_data = pc_plus4;
      default: sel_data = 32'd0;
    endcase
  end

  // Hazard check uses only the registered busy vector (no same-cycle bypass)
  assign stall_out = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);

  // A real commit needs a legal, non-x0 result outside a flush
  assign commit = wb_valid & (wb_rd != 5'd0) & (wb_sel != 2'b11) & ~flush;

  // Issue marks its destination pending only when it actually proceeds
  assign set_en = issue_valid & ~stall_out & ~flush & (issue_rd != 5'd0);

  // Any retirement releases its destination, even an illegal one, so a faulting producer cannot deadlock issue
  assign clr_en = wb_valid & (wb_rd != 5'd0);

  // Single writeback pipeline register; address and data load even when the write is suppressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_RF <= 1'b0;
      A3    <= 5'd0;
      WD3   <= 32'd0;
    end else begin
      we_RF <= commit;
      A3    <= wb_rd;
      WD3   <= sel_data;
    end
  end

  // Pending-write bits: flush wipes everything; otherwise clear then set so a new producer wins a same-index collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 32'd0;
    end else if (flush) begin
      busy <= 32'd0;
    end else begin
      if (clr_en) busy[wb_rd] <= 1'b0;
      if (set_en) busy[issue_rd] <= 1'b1;
    end
  end

  // Count committed register writes, wrapping naturally at 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= 32'd0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: doc/writeback_scoreboard.md
WRITEBACK_SCOREBOARD -- requirements
Module: writeback_scoreboard

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 issue_valid  input  1  decode presents an instruction this cycle.
REQ-005 issue_rd  input  5  destination register of issuing instruction.
REQ-006 issue_rs1, issue_rs2  input  5 each  source registers of issuing instruction.
REQ-007 wb_valid  input  1  memory stage presents a result to retire.
REQ-008 wb_rd  input  5  destination register of retiring result.
REQ-009 wb_sel  input  2  result select: 00 alu_result, 01 mem_data, 10 pc_plus4, 11 illegal.
REQ-010 alu_result, mem_data, pc_plus4  input  32 each  candidate writeback values.
REQ-011 flush  input  1  squash in-flight state.
REQ-012 stall_out  output  1  issuing instruction must be held (combinational).
REQ-013 we_RF  output  1  register-file write enable (registered).
REQ-014 A3  output  5  register-file write address (registered).
REQ-015 WD3  output  32  register-file write data (registered).
REQ-016 busy  output  32  per-register pending-write bits (registered).
REQ-017 retire_cnt  output  32  count of committed register writes (registered).

Function
REQ-018 Writeback path SHALL be a single pipeline register: wb inputs sampled at posedge N appear on we_RF/A3/WD3 after posedge N, held one full cycle so the register file may write on the following falling edge.
REQ-019 WD3 SHALL be selected by wb_sel per REQ-009; for wb_sel=11 WD3 SHALL load 0 and we_RF SHALL load 0.
REQ-020 we_RF SHALL load 1 only when wb_valid=1, wb_rd!=0, wb_sel!=11 and flush=0; otherwise 0.
REQ-021 When we_RF loads 0, A3 and WD3 SHALL still load the sampled wb_rd and selected value (don't-care to consumer, deterministic for checking).
REQ-022 stall_out SHALL equal issue_valid AND (busy[issue_rs1] OR busy[issue_rs2] OR busy[issue_rd]), using the registered busy vector; no same-cycle bypass.
REQ-023 busy[0] SHALL be constant 0; index 0 never set, never stalls.
REQ-024 Set: at posedge, if issue_valid=1, stall_out=0, flush=0 and issue_rd!=0, busy[issue_rd] SHALL become 1.
REQ-025 Clear: at posedge, if wb_valid=1 and wb_rd!=0, busy[wb_rd] SHALL become 0 (also for wb_sel=11, so a faulting producer cannot deadlock).
REQ-026 Simultaneous set and clear of the same index SHALL leave the bit set (new producer wins).
REQ-027 flush=1 at posedge SHALL clear all busy bits and suppress the set and the commit of that cycle; it SHALL NOT modify retire_cnt beyond suppressing that increment.
REQ-028 retire_cnt SHALL increment by 1 at each posedge where we_RF loads 1; wraps 0xFFFFFFFF -> 0.
REQ-029 Retiring to a register whose busy bit is already 0 SHALL still commit and SHALL leave busy unchanged.

Reset
REQ-030 While rst=1, immediately and independent of clk: busy=0, we_RF=0, A3=0, WD3=0, retire_cnt=0.
REQ-031 Reset asserted mid-operation SHALL discard any captured writeback; first commit possible at the first posedge after rst deasserts.
REQ-032 stall_out during reset SHALL follow REQ-022 with busy=0 (i.e. 0).

Verification
REQ-033 Issue rd=5, next cycle issue rs1=5 -> stall_out=1; wb_valid rd=5 sel=00 alu=0x1234 -> next cycle we_RF=1, A3=5, WD3=0x1234, busy[5]=0, stall_out=0.
REQ-034 wb_valid with wb_rd=0, sel=01 -> we_RF=0, retire_cnt unchanged; issue rd=0 -> busy stays 0.
REQ-035 Same cycle: issue rd=7 (no stall) and wb_valid rd=7 -> busy[7]=1 after the edge, we_RF=1, A3=7.
REQ-036 busy[3],busy[9] set, pulse flush with wb_valid rd=3 -> busy=0, we_RF=0, retire_cnt unchanged.
REQ-037 wb_sel=11, rd=4 with busy[4]=1 -> we_RF=0, WD3=0, busy[4]=0.
REQ-038 Force retire_cnt to 0xFFFFFFFF via 2^32-1 commits (or preload in bench) then one commit -> retire_cnt=0; assert rst asynchronously between edges -> all outputs 0 before next posedge.
